// File: rtl/unix_to_calendar_if.sv
// unix_to_calendar_if: start/done handshake and calendar result bundle for unix_to_calendar.
//   master : requester (drives start, unix_in, tz_min; observes busy/done/err and fields)
//   slave  : converter (observes the request; drives busy/done/err and fields)
// Signals:
//   start    request pulse, sampled by the converter only when idle
//   unix_in  WIDTH-bit Unix timestamp
//   tz_min   signed minutes east of UTC (only with TZ_OFFSET_EN defined)
//   busy     conversion in progress
//   done     one-cycle completion pulse
//   err      timestamp earlier than the epoch (valid with done)
//   year/month/day/hour/minute/second  calendar fields
// Optional feature macro: TZ_OFFSET_EN.
interface unix_to_calendar_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] unix_in;
`ifdef TZ_OFFSET_EN
    logic [11:0]      tz_min;
`endif
    logic             busy;
    logic             done;
    logic             err;
    logic [11:0]      year;
    logic [3:0]       month;
    logic [4:0]       day;
    logic [4:0]       hour;
    logic [5:0]       minute;
    logic [5:0]       second;

    modport master (
`ifdef TZ_OFFSET_EN
        output tz_min,
`endif
        output start, unix_in,
        input  busy, done, err, year, month, day, hour, minute, second
    );

    modport slave (
`ifdef TZ_OFFSET_EN
        input  tz_min,
`endif
        input  start, unix_in,
        output busy, done, err, year, month, day, hour, minute, second
    );
endinterface

// File: rtl/unix_to_calendar.sv
// unix_to_calendar: sequential Unix timestamp to Gregorian calendar converter.
// A single restoring divider is reused for seconds->days, seconds-of-day->hours and
// remainder->minutes; years and months are then peeled off by subtraction loops.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any conversion in flight)
//   bus    unix_to_calendar_if.slave: start/unix_in[/tz_min] in; busy/done/err and
//          year/month/day/hour/minute/second out (all registered)
// Parameters:
//   WIDTH      timestamp width (32..40)
//   BASE_YEAR  epoch year (Jan 1, 00:00:00 of this year)
//   BASE_SECS  Unix seconds at the epoch; must agree with BASE_YEAR
// Optional feature macro: TZ_OFFSET_EN adds the tz_min offset (minutes east of UTC).
module unix_to_calendar #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     BASE_YEAR = 2020,
    parameter longint unsigned BASE_SECS = 64'd1577836800
) (
    input logic               clk,
    input logic               rst_n,
    unix_to_calendar_if.slave bus
);

    localparam int unsigned SW       = WIDTH + 2;
    localparam logic [17:0] DIV_DAY  = 18'd86400;
    localparam logic [17:0] DIV_HOUR = 18'd3600;
    localparam logic [17:0] DIV_MIN  = 18'd60;

    typedef enum logic [2:0] {
        StIdle, StLoad, StDdiv, StHdiv, StMdiv, StYear, StMonth, StDone
    } state_e;

    state_e state_q, state_d;

    // Request capture
    logic [WIDTH-1:0] unix_q;
`ifdef TZ_OFFSET_EN
    logic [11:0]      tz_q;
`endif

    // Working registers
    logic [WIDTH-1:0] q_q;     // dividend shifting out MSB-first, quotient shifting in
    logic [16:0]      rem_q;
    logic [5:0]       cnt_q;
    logic [WIDTH-1:0] days_q;
    logic [11:0]      yr_q;
    logic [3:0]       mon_q;
    logic [4:0]       hr_q;
    logic [5:0]       min_q;
    logic [5:0]       sec_q;

    // Output registers
    logic        busy_q, done_q, err_q;
    logic [11:0] year_q;
    logic [3:0]  month_q;
    logic [4:0]  day_q;
    logic [4:0]  hour_q;
    logic [5:0]  minute_q;
    logic [5:0]  second_q;

    function automatic logic is_leap(input logic [11:0] y);
        return (y[1:0] == 2'd0) &&
               (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
    endfunction

    function automatic logic [8:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                    return leap ? 9'd29 : 9'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 9'd30;
            default:                 return 9'd31;
        endcase
    endfunction

    // Seconds since the epoch, signed at WIDTH+2 bits
    logic [SW-1:0] s_val;
    logic          s_bad;

    always_comb begin
        s_val = {2'b00, unix_q} - SW'(BASE_SECS);
`ifdef TZ_OFFSET_EN
        s_val = s_val + ({{(SW - 12){tz_q[11]}}, tz_q} * SW'(60));
`endif
        // Negative (before the epoch) or, for odd parameter sets, not representable
        s_bad = |s_val[SW-1:WIDTH];
    end

    // Shared restoring divider step
    logic [17:0]      divisor;
    logic [17:0]      rem_sh;
    logic             ge;
    logic [16:0]      step_rem;
    logic [WIDTH-1:0] step_q;
    logic             last_iter;

    always_comb begin
        divisor   = DIV_DAY;
        last_iter = 1'b0;
        case (state_q)
            StDdiv: begin
                divisor   = DIV_DAY;
                last_iter = (cnt_q == 6'(WIDTH - 1));
            end
            StHdiv: begin
                divisor   = DIV_HOUR;
                last_iter = (cnt_q == 6'd16);
            end
            StMdiv: begin
                divisor   = DIV_MIN;
                last_iter = (cnt_q == 6'd11);
            end
            default: ;
        endcase
        rem_sh   = {rem_q, q_q[WIDTH-1]};
        ge       = (rem_sh >= divisor);
        step_rem = ge ? 17'(rem_sh - divisor) : rem_sh[16:0];
        step_q   = {q_q[WIDTH-2:0], ge};
    end

    // Year / month loop conditions
    logic [8:0] ylen;
    logic [8:0] mlen;
    logic       year_adv;
    logic       month_adv;

    always_comb begin
        ylen      = is_leap(yr_q) ? 9'd366 : 9'd365;
        mlen      = month_len(mon_q, is_leap(yr_q));
        year_adv  = (days_q >= WIDTH'(ylen));
        month_adv = (days_q >= WIDTH'(mlen));
    end

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StLoad;
            StLoad:  state_d = s_bad ? StDone : StDdiv;
            StDdiv:  if (last_iter) state_d = StHdiv;
            StHdiv:  if (last_iter) state_d = StMdiv;
            StMdiv:  if (last_iter) state_d = StYear;
            StYear:  if (!year_adv) state_d = StMonth;
            StMonth: if (!month_adv) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unix_q <= '0;
`ifdef TZ_OFFSET_EN
            tz_q   <= '0;
`endif
            q_q    <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            days_q <= '0;
            yr_q   <= '0;
            mon_q  <= '0;
            hr_q   <= '0;
            min_q  <= '0;
            sec_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        unix_q <= bus.unix_in;
`ifdef TZ_OFFSET_EN
                        tz_q   <= bus.tz_min;
`endif
                    end
                end
                StLoad: begin
                    q_q   <= s_val[WIDTH-1:0];
                    rem_q <= '0;
                    cnt_q <= '0;
                    yr_q  <= 12'(BASE_YEAR);
                    mon_q <= 4'd1;
                end
                StDdiv, StHdiv, StMdiv: begin
                    cnt_q <= cnt_q + 6'd1;
                    rem_q <= step_rem;
                    q_q   <= step_q;
                    if (last_iter) begin
                        // Hand the remainder to the next division, left-aligned so the
                        // same MSB-first step works for every divisor.
                        cnt_q <= '0;
                        rem_q <= '0;
                        case (state_q)
                            StDdiv: begin
                                days_q <= step_q;
                                q_q    <= {step_rem, {(WIDTH - 17){1'b0}}};
                            end
                            StHdiv: begin
                                hr_q <= step_q[4:0];
                                q_q  <= {step_rem[11:0], {(WIDTH - 12){1'b0}}};
                            end
                            default: begin
                                min_q <= step_q[5:0];
                                sec_q <= step_rem[5:0];
                            end
                        endcase
                    end
                end
                StYear: begin
                    if (year_adv) begin
                        days_q <= days_q - WIDTH'(ylen);
                        yr_q   <= yr_q + 12'd1;
                    end
                end
                StMonth: begin
                    if (month_adv) begin
                        days_q <= days_q - WIDTH'(mlen);
                        mon_q  <= mon_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; fields change only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            year_q   <= '0;
            month_q  <= '0;
            day_q    <= '0;
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
        end else begin
            busy_q <= (state_d != StIdle) && (state_d != StDone);
            done_q <= (state_d == StDone);
            if (state_q == StLoad && s_bad) begin
                err_q    <= 1'b1;
                year_q   <= '0;
                month_q  <= '0;
                day_q    <= '0;
                hour_q   <= '0;
                minute_q <= '0;
                second_q <= '0;
            end else if (state_q == StMonth && !month_adv) begin
                err_q    <= 1'b0;
                year_q   <= yr_q;
                month_q  <= mon_q;
                day_q    <= days_q[4:0] + 5'd1;
                hour_q   <= hr_q;
                minute_q <= min_q;
                second_q <= sec_q;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.year   = year_q;
    assign bus.month  = month_q;
    assign bus.day    = day_q;
    assign bus.hour   = hour_q;
    assign bus.minute = minute_q;
    assign bus.second = second_q;

endmodule
